mem_stage_ob: RTL

- Parametrised successor of the single-entry memory stage; sits between EXE and WB.
- Holds up to DEPTH in-order instructions whose data-memory requests are already issued, so EXE can issue the next request before the previous data_ok returns.
- Matches in-order data_ok responses to the oldest waiting entry and performs load byte/half/word extraction with sign extension.
- On exception/ertn cancel, flushes all entries and discards the responses still in flight.

---
 rtl/mem_stage_ob.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_stage_ob.sv
// mem_stage_ob: multi-entry MEM stage buffering issued data requests, matching in-order data_ok and extracting loads.
// Define MEM_DATA_BYPASS_EN to forward data_sram_rdata to WB in the data_ok cycle when it targets the head entry.
module mem_stage_ob #(
    parameter int DEPTH = 2,
    parameter int EXC_W = 7
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       exe_to_mem_valid,
    output logic                       mem_allowin,
    input  logic [31:0]                exe_pc,
    input  logic [31:0]                exe_result,
    input  logic                       exe_rf_we,
    input  logic [4:0]                 exe_rf_waddr,
    input  logic                       exe_req_issued,
    input  logic [3:0]                 exe_ld_op,
    input  logic                       exe_is_load,
    input  logic [EXC_W-1:0]           exe_exc,
    input  logic                       exe_orphan_req,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       cancel_exc_ertn,
    input  logic                       wb_allowin,
    output logic                       mem_to_wb_valid,
    output logic [31:0]                mem_pc,
    output logic                       mem_rf_we,
    output logic [4:0]                 mem_rf_waddr,
    output logic [31:0]                mem_rf_wdata,
    output logic [EXC_W-1:0]           mem_exc,
    output logic                       mem_exc_flush,
    output logic                       mem_ld_pending,
    output logic [$clog2(DEPTH+1)-1:0] mem_count
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);
    localparam int DW = $clog2(DEPTH+3);

    logic [31:0]      r_pc    [DEPTH];
    logic [31:0]      r_res   [DEPTH];
    logic [4:0]       r_waddr [DEPTH];
    logic [3:0]       r_ldop  [DEPTH];
    logic [31:0]      r_rdata [DEPTH];
    logic [EXC_W-1:0] r_exc   [DEPTH];
    logic [DEPTH-1:0] r_vld, r_done, r_iss, r_ld, r_we;
    logic [PW-1:0]    r_head, r_tail;
    logic [CW-1:0]    r_count;
    logic [DW-1:0]    r_disc;

    logic [PW-1:0] w_j, w_rp;
    logic          w_hit, w_ldp;
    logic [DW-1:0] w_pend, w_tot;
    logic          w_hvld, w_hexc, w_fill, w_byp, w_ready, w_pop, w_push, w_dec;
    logic [31:0]   w_rdata, w_res, w_ldv, w_wdata;
    logic [3:0]    w_op;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (int'(p) == DEPTH-1) ? '0 : p + 1'b1;
    endfunction

    // The response target is the oldest issued entry still waiting, searched from the head.
    always_comb begin
        w_j    = '0;
        w_rp   = '0;
        w_hit  = 1'b0;
        w_pend = '0;
        w_ldp  = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            w_j = PW'((int'(r_head) + k) % DEPTH);
            if (!w_hit && r_vld[w_j] && r_iss[w_j] && !r_done[w_j]) begin
                w_hit = 1'b1;
                w_rp  = w_j;
            end
            w_pend = w_pend + DW'(r_vld[k] & r_iss[k] & ~r_done[k]);
            w_ldp  = w_ldp | (r_vld[k] & r_ld[k] & ~r_done[k]);
        end
    end

    assign w_hvld = r_vld[r_head];
    assign w_hexc = |r_exc[r_head];
    assign w_dec  = data_sram_data_ok & (r_disc != '0);
    assign w_fill = data_sram_data_ok & (r_disc == '0) & w_hit;
`ifdef MEM_DATA_BYPASS_EN
    assign w_byp  = w_fill & (w_rp == r_head);
`else
    assign w_byp  = 1'b0;
`endif
    assign w_rdata = w_byp ? data_sram_rdata : r_rdata[r_head];
    assign w_ready = w_hvld & (w_hexc | ~r_iss[r_head] | r_done[r_head] | w_byp);
    assign mem_to_wb_valid = ~cancel_exc_ertn & w_ready;
    assign w_pop       = mem_to_wb_valid & wb_allowin;
    assign mem_allowin = ~cancel_exc_ertn & ((r_count < CW'(DEPTH)) | w_pop);
    assign w_push      = exe_to_mem_valid & mem_allowin;
    assign w_tot       = r_disc + w_pend + DW'(exe_orphan_req);

    assign w_res  = r_res[r_head];
    assign w_op   = r_ldop[r_head];
    assign w_byte = w_rdata[{w_res[1:0], 3'b000} +: 8];
    assign w_half = w_res[1] ? w_rdata[31:16] : w_rdata[15:0];
    assign w_ldv  = w_op[1] ? w_rdata :
                    w_op[2] ? {{16{w_op[0] & w_half[15]}}, w_half} :
                              {{24{w_op[0] & w_byte[7]}}, w_byte};
    assign w_wdata = r_ld[r_head] ? w_ldv : w_res;

    assign mem_pc         = mem_to_wb_valid ? r_pc[r_head] : '0;
    assign mem_rf_we      = mem_to_wb_valid & r_we[r_head];
    assign mem_rf_waddr   = mem_to_wb_valid ? r_waddr[r_head] : '0;
    assign mem_rf_wdata   = mem_to_wb_valid ? w_wdata : '0;
    assign mem_exc        = mem_to_wb_valid ? r_exc[r_head] : '0;
    assign mem_exc_flush  = w_hvld & w_hexc;
    assign mem_ld_pending = w_ldp;
    assign mem_count      = r_count;

    // Push is ordered after fill and pop so a full-buffer refill of the head slot wins.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_disc  <= '0;
            r_vld   <= '0;
            r_done  <= '0;
        end else if (cancel_exc_ertn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
            r_done  <= '0;
            r_disc  <= w_tot - DW'(data_sram_data_ok && (w_tot != '0));
        end else begin
            r_disc <= r_disc + DW'(exe_orphan_req) - DW'(w_dec);
            if (w_fill) begin
                r_rdata[w_rp] <= data_sram_rdata;
                r_done[w_rp]  <= 1'b1;
            end
            if (w_pop) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= nxt(r_head);
            end
            if (w_push) begin
                r_pc[r_tail]    <= exe_pc;
                r_res[r_tail]   <= exe_result;
                r_we[r_tail]    <= exe_rf_we;
                r_waddr[r_tail] <= exe_rf_waddr;
                r_ldop[r_tail]  <= exe_ld_op;
                r_ld[r_tail]    <= exe_is_load;
                r_iss[r_tail]   <= exe_req_issued;
                r_exc[r_tail]   <= exe_exc;
                r_vld[r_tail]   <= 1'b1;
                r_done[r_tail]  <= 1'b0;
                r_tail          <= nxt(r_tail);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end
endmodule
